// File: rtl/load_store_unit.sv
// Load/store unit between MEM-stage control and a word-addressed data memory.
// Sub-word stores are done as a read-modify-write; loads extract and extend a lane.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LP_MEM_WORDS = ADDR_WIDTH'(MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_LOAD, S_WRITE, S_RMW_RD, S_RMW_WR
  } state_t;

  state_t                r_state;
  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [1:0]            r_err;
  logic [31:0]           r_merge;
  logic                  r_resp_valid;
  logic [31:0]           r_resp_rdata;
  logic [1:0]            r_resp_err;

  logic                  w_misalign;
  logic                  w_oor;
  logic                  w_accept;
  logic                  w_active;

  function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [1:0] size, input logic uns);
    logic [31:0]        shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    shifted = word >> {lane, 3'b000};
    b       = shifted[7:0];
    h       = shifted[15:0];
    case (size)
      2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [1:0] lane,
                                          input logic [1:0] size, input logic [31:0] wdata);
    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] res;
    sh = {lane, 3'b000};
    case (size)
      2'b00: begin
        mask = 32'h0000_00FF << sh;
        res  = (word & ~mask) | ((wdata & 32'h0000_00FF) << sh);
      end
      2'b01: begin
        mask = 32'h0000_FFFF << sh;
        res  = (word & ~mask) | ((wdata & 32'h0000_FFFF) << sh);
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

  // Misalignment outranks the range check when both apply.
  assign w_misalign = (req_size == 2'b11) ||
                      ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_oor      = {2'b00, req_addr[ADDR_WIDTH-1:2]} >= LP_MEM_WORDS;

  assign req_ready  = rst_n && (r_state == S_IDLE);
  assign w_accept   = req_valid && req_ready;
  assign w_active   = (r_state == S_LOAD) || (r_state == S_WRITE) ||
                      (r_state == S_RMW_RD) || (r_state == S_RMW_WR);

  // Memory strobes are gated by rst_n so a reset edge can never commit a write.
  assign mem_read   = rst_n && ((r_state == S_LOAD) || (r_state == S_RMW_RD));
  assign mem_write  = rst_n && ((r_state == S_WRITE) || (r_state == S_RMW_WR));
  assign mem_addr   = (rst_n && w_active) ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wdata  = !rst_n                ? 32'd0 :
                      (r_state == S_WRITE)  ? r_wdata :
                      (r_state == S_RMW_WR) ? f_merge(r_merge, r_addr[1:0], r_size, r_wdata) :
                      32'd0;

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 2'b00;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_err      <= w_misalign ? 2'b01 : 2'b10;
            if (w_misalign || w_oor)   r_state <= S_ERR;
            else if (!req_write)       r_state <= S_LOAD;
            else if (req_size == 2'b10) r_state <= S_WRITE;
            else                       r_state <= S_RMW_RD;
          end
        end
        S_ERR: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= 32'd0;
          r_resp_err   <= r_err;
          r_state      <= S_IDLE;
        end
        S_LOAD: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= f_extract(mem_rdata, r_addr[1:0], r_size, r_unsigned);
          r_resp_err   <= 2'b00;
          r_state      <= S_IDLE;
        end
        S_RMW_RD: begin
          r_merge <= mem_rdata;
          r_state <= S_RMW_WR;
        end
        S_WRITE, S_RMW_WR: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= 32'd0;
          r_resp_err   <= {1'b0, 1'b0 & r_write};
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 256-word behavioural data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .MEM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'd0;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                      input logic [31:0] exp_rd, input logic [1:0] exp_err,
                      input int exp_nrd, input int exp_nwr, input logic [31:0] exp_wd);
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] lastwd;
    logic [31:0] rd;
    logic [1:0]  er;
    lat = 0; nrd = 0; nwr = 0; lastwd = 32'd0; rd = 32'hx; er = 2'bx;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    #1 chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_0BAD;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_read) nrd++;
      if (mem_write) begin
        nwr++;
        lastwd = mem_wdata;
      end
      if (resp_valid) begin
        lat = k;
        rd  = resp_rdata;
        er  = resp_err;
        break;
      end
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".err"}, 32'(er), 32'(exp_err));
    chk({tag, ".nrd"}, 32'(nrd), 32'(exp_nrd));
    chk({tag, ".nwr"}, 32'(nwr), 32'(exp_nwr));
    if (exp_nwr != 0) chk({tag, ".wdata"}, lastwd, exp_wd);
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, ".hold"}, resp_rdata, exp_rd);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.rvalid", 32'(resp_valid), 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    chk("rst.err", 32'(resp_err), 32'd0);
    chk("rst.mem", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst.maddr", mem_addr, 32'd0);
    chk("rst.mwdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    #1 chk("rst.ready_hi", 32'(req_ready), 32'd1);

    xfer("sw10",  1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 2'b00, 0, 1, 32'hDEADBEEF);
    xfer("lw10",  0, 2'b10, 0, 32'h10, 32'h0,        2, 32'hDEADBEEF, 2'b00, 1, 0, 32'h0);
    xfer("sb11",  1, 2'b00, 0, 32'h11, 32'h55AA,     3, 32'h0, 2'b00, 1, 1, 32'hDEADAAEF);
    xfer("lb11",  0, 2'b00, 0, 32'h11, 32'h0,        2, 32'hFFFFFFAA, 2'b00, 1, 0, 32'h0);
    xfer("lbu11", 0, 2'b00, 1, 32'h11, 32'h0,        2, 32'h000000AA, 2'b00, 1, 0, 32'h0);
    xfer("sh12",  1, 2'b01, 0, 32'h12, 32'h8001,     3, 32'h0, 2'b00, 1, 1, 32'h8001AAEF);
    chk("mem4", mem[4], 32'h8001AAEF);
    xfer("lh12",  0, 2'b01, 0, 32'h12, 32'h0,        2, 32'hFFFF8001, 2'b00, 1, 0, 32'h0);
    xfer("lhu12", 0, 2'b01, 1, 32'h12, 32'h0,        2, 32'h00008001, 2'b00, 1, 0, 32'h0);
    xfer("lh10",  0, 2'b01, 0, 32'h10, 32'h0,        2, 32'hFFFFAAEF, 2'b00, 1, 0, 32'h0);
    xfer("lb13",  0, 2'b00, 0, 32'h13, 32'h0,        2, 32'hFFFFFF80, 2'b00, 1, 0, 32'h0);
    xfer("lbu10", 0, 2'b00, 1, 32'h10, 32'h0,        2, 32'h000000EF, 2'b00, 1, 0, 32'h0);

    xfer("e_lw13",  0, 2'b10, 0, 32'h13,  32'h0, 2, 32'h0, 2'b01, 0, 0, 32'h0);
    xfer("e_sh401", 1, 2'b01, 0, 32'h401, 32'h1234, 2, 32'h0, 2'b01, 0, 0, 32'h0);
    xfer("e_lw400", 0, 2'b10, 0, 32'h400, 32'h0, 2, 32'h0, 2'b10, 0, 0, 32'h0);
    xfer("e_sz11",  0, 2'b11, 0, 32'h10,  32'h0, 2, 32'h0, 2'b01, 0, 0, 32'h0);
    chk("mem4_err", mem[4], 32'h8001AAEF);

    // Back-to-back: valid held high, second request taken in the response cycle.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_write = 1'b1; req_size = 2'b00; req_addr = 32'h14; req_wdata = 32'h0000_0077;
    @(negedge clk);
    chk("b2b.ready_load", 32'(req_ready), 32'd0);
    chk("b2b.rd_load", 32'(mem_read), 32'd1);
    @(negedge clk);
    chk("b2b.rvalid1", 32'(resp_valid), 32'd1);
    chk("b2b.rdata1", resp_rdata, 32'h8001AAEF);
    chk("b2b.ready_resp", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b.ready_rmwrd", 32'(req_ready), 32'd0);
    chk("b2b.rd_rmw", 32'(mem_read), 32'd1);
    @(negedge clk);
    chk("b2b.ready_rmwwr", 32'(req_ready), 32'd0);
    chk("b2b.wr_rmw", 32'(mem_write), 32'd1);
    chk("b2b.wdata", mem_wdata, 32'h0000_0077);
    @(negedge clk);
    chk("b2b.rvalid2", 32'(resp_valid), 32'd1);
    chk("mem5", mem[5], 32'h0000_0077);

    // Reset asserted while the RMW write is pending.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h33;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmr.rd", 32'(mem_read), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rmr.wr_gated", 32'(mem_write), 32'd0);
    @(negedge clk);
    chk("rmr.mem4", mem[4], 32'h8001AAEF);
    chk("rmr.rvalid", 32'(resp_valid), 32'd0);
    chk("rmr.rdata", resp_rdata, 32'd0);
    chk("rmr.err", 32'(resp_err), 32'd0);
    chk("rmr.maddr", mem_addr, 32'd0);
    chk("rmr.ready_lo", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1 chk("rmr.ready_hi", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("rmr.rvalid_after", 32'(resp_valid), 32'd0);
    chk("rmr.mem_idle", {30'd0, mem_read, mem_write}, 32'd0);
    xfer("lw10_post", 0, 2'b10, 0, 32'h10, 32'h0, 2, 32'h8001AAEF, 2'b00, 1, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
